flex_rcv_block: RTL and testbench
=================================

FLEX_RCV_BLOCK -- requirements
Module: flex_rcv_block

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 10, clk cycles per serial bit, legal 8..1023.
REQ-003 Parameter FIFO_DEPTH, default 4, receive FIFO entries, power of 2, legal 2..16.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 serial_in  input  1  asynchronous serial line, idle high, LSB first.
REQ-007 data_read  input  1  one-cycle pulse; pops FIFO head, clears overrun_error.
REQ-008 rx_data  output  DATA_BITS  FIFO head word (show-ahead).
REQ-009 data_ready  output  1  high while FIFO non-empty.
REQ-010 overrun_error  output  1  sticky; good frame arrived while FIFO full.
REQ-011 framing_error  output  1  last frame had stop bit 0.
REQ-012 rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 serial_in SHALL pass a 2-flop synchroniser (reset value 1) before any use.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, plus PARITY only when RCV_PARITY_EN is defined.
REQ-015 IDLE -> START on synchronised 1->0 transition; bit counter reloads to CLKS_PER_BIT/2.
REQ-016 START samples line at counter expiry: 0 -> DATA, 1 -> IDLE (false start, no flag change).
REQ-017 DATA samples every CLKS_PER_BIT cycles, shifting DATA_BITS bits LSB first, then -> STOP (or PARITY).
REQ-018 STOP samples one bit period later: 1 -> push word, 0 -> set framing_error, discard word; both -> IDLE next cycle.
REQ-019 Mid-bit sampling SHALL recover frames with bit period within +/-4% of CLKS_PER_BIT.
REQ-020 Pushed word SHALL appear on rx_data/data_ready one clk after the stop-sample edge.
REQ-021 framing_error (and parity_error) SHALL clear at the next accepted start bit (START -> DATA).
REQ-022 Push with FIFO full and no same-cycle data_read: word dropped, overrun_error set, existing contents unchanged.
REQ-023 Push and data_read same cycle with FIFO full: both performed, no overrun.
REQ-024 data_read with FIFO empty SHALL be ignored except clearing overrun_error.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; rx_count SHALL equal pushes minus pops, saturating at FIFO_DEPTH.
REQ-026 A new start bit SHALL be detectable the cycle after returning to IDLE (back-to-back frames, no idle gap).

Reset
REQ-027 n_rst low SHALL asynchronously force FSM to IDLE, empty FIFO, rx_count=0, data_ready=0, all error flags 0, rx_data all ones.
REQ-028 Reset mid-frame SHALL discard the partial frame; reception restarts only on a fresh 1->0 edge after release.

Configuration
REQ-029 Macro RCV_PARITY_EN defined: one even-parity bit follows data; output port parity_error (1 bit) added; mismatch sets parity_error, word discarded, stop bit still checked.
REQ-030 RCV_PARITY_EN undefined: no PARITY state, no parity_error port, frame = start + DATA_BITS + stop.

Verification
REQ-031 Defaults, send 0xD5 stop 1 at 10 clk/bit -> rx_data=0xD5, data_ready=1, errors 0; data_read -> data_ready=0 next cycle.
REQ-032 Send 0xD5 at 9.6 then 10.4 clk/bit -> both received correctly, rx_count=2.
REQ-033 FIFO_DEPTH=4, five frames 0x01..0x05 no reads -> overrun_error=1, rx_count=4, pops yield 0x01..0x04.
REQ-034 Send 0xD5 stop 0 -> framing_error=1, data_ready=0; then 0x6A stop 1 -> framing_error=0, rx_data=0x6A.
REQ-035 Half-bit (5 clk) low glitch on idle line -> no push, no flags; assert n_rst mid-frame -> all outputs at reset values.
REQ-036 RCV_PARITY_EN, DATA_BITS=7, send 0x35 with wrong parity -> parity_error=1, no push; correct parity -> rx_data=0x35.

Source files
------------

// File: rtl/flex_rcv_block.sv
// flex_rcv_block: mid-bit sampling serial receiver feeding a show-ahead receive FIFO.
// Define RCV_PARITY_EN to add an even-parity bit after the data and a parity_error output.
module flex_rcv_block #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 10,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         serial_in,
   input  logic                         data_read,
   output logic [DATA_BITS-1:0]         rx_data,
   output logic                         data_ready,
   output logic                         overrun_error,
   output logic                         framing_error,
`ifdef RCV_PARITY_EN
   output logic                         parity_error,
`endif
   output logic [$clog2(FIFO_DEPTH):0]  rx_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
   // half a bit less one cycle, absorbing the edge detector's extra register stage
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef RCV_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;
   state_t state, next_state;
   logic [1:0] sync;
   logic [2:0] warm;
   logic s, prev, fall, tick, last_bit;
   logic start_ok, sample_bit, push, frame_bad, par_bad, par_err_q;
   logic [CW-1:0] cnt;
   logic [3:0] bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic full, pop, wr_en, drop;
   assign s        = sync[1];
   assign fall     = warm[2] & prev & ~s;
   assign tick     = cnt == '0;
   assign last_bit = bit_idx == 4'(DATA_BITS - 1);
   // warm keeps the reset value of the synchroniser from posing as a falling edge
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         sync <= '1;
         prev <= 1'b1;
         warm <= '0;
      end else begin
         sync <= {sync[0], serial_in};
         prev <= s;
         warm <= {warm[1:0], 1'b1};
      end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else        state <= next_state;
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  next_state = fall ? START : IDLE;
         START: if (tick) next_state = s ? IDLE : DATA;
`ifdef RCV_PARITY_EN
         DATA:   if (tick && last_bit) next_state = PARITY;
         PARITY: if (tick) next_state = STOP;
`else
         DATA:  if (tick && last_bit) next_state = STOP;
`endif
         STOP:  if (tick) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end
   always_comb begin
      start_ok   = state == START && tick && !s;
      sample_bit = state == DATA && tick;
      frame_bad  = state == STOP && tick && !s;
      push       = state == STOP && tick && s && !par_err_q;
`ifdef RCV_PARITY_EN
      par_bad    = state == PARITY && tick && (^{shift, s});
`else
      par_bad    = 1'b0;
`endif
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         cnt           <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         framing_error <= 1'b0;
         par_err_q     <= 1'b0;
      end else begin
         cnt           <= (state == IDLE) ? HALF_RELOAD : tick ? FULL_RELOAD : cnt - 1'b1;
         bit_idx       <= (state != DATA) ? '0 : sample_bit ? bit_idx + 1'b1 : bit_idx;
         shift         <= sample_bit ? {s, shift[DATA_BITS-1:1]} : shift;
         framing_error <= start_ok ? 1'b0 : framing_error | frame_bad;
         par_err_q     <= start_ok ? 1'b0 : par_err_q | par_bad;
      end
`ifdef RCV_PARITY_EN
   assign parity_error = par_err_q;
`endif
   assign full  = rx_count == (AW + 1)'(FIFO_DEPTH);
   assign pop   = data_read && data_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= shift;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         rx_count      <= '0;
         overrun_error <= 1'b0;
      end else begin
         wr_ptr        <= wr_ptr + AW'(wr_en);
         rd_ptr        <= rd_ptr + AW'(pop);
         rx_count      <= rx_count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
         overrun_error <= data_read ? 1'b0 : overrun_error | drop;
      end
   assign data_ready = rx_count != '0;
   assign rx_data    = data_ready ? mem[rd_ptr] : '1;
endmodule

// File: tb/tb_flex_rcv_block.sv
// tb_flex_rcv_block: directed and random frames checked against a word-level FIFO model.
module tb_flex_rcv_block;
`ifdef RCV_PARITY_EN
   localparam int DB = 7;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int DB = 8;
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int DEPTH = 4;
   logic tb_clk = 1'b0;
   logic n_rst = 1'b1;
   logic serial_in = 1'b1;
   logic data_read = 1'b0;
   logic [DB-1:0] rx_data;
   logic data_ready, overrun_error, framing_error;
   logic [2:0] rx_count;
`ifdef RCV_PARITY_EN
   logic parity_error;
`endif
   int errors = 0;
   int checks = 0;
   logic [DB-1:0] q[$];
   logic m_ov, m_fe, m_pe;

   always #5 tb_clk = ~tb_clk;

   flex_rcv_block #(.DATA_BITS(DB), .CLKS_PER_BIT(10), .FIFO_DEPTH(DEPTH)) dut (
      .clk(tb_clk),
      .n_rst(n_rst),
      .serial_in(serial_in),
      .data_read(data_read),
      .rx_data(rx_data),
      .data_ready(data_ready),
      .overrun_error(overrun_error),
      .framing_error(framing_error),
`ifdef RCV_PARITY_EN
      .parity_error(parity_error),
`endif
      .rx_count(rx_count)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rx_data"}, 16'(rx_data), q.size() != 0 ? 16'(q[0]) : 16'({DB{1'b1}}));
      chk({tag, ".data_ready"}, 16'(data_ready), 16'(q.size() != 0));
      chk({tag, ".rx_count"}, 16'(rx_count), 16'(q.size()));
      chk({tag, ".overrun"}, 16'(overrun_error), 16'(m_ov));
      chk({tag, ".framing"}, 16'(framing_error), 16'(m_fe));
`ifdef RCV_PARITY_EN
      chk({tag, ".parity"}, 16'(parity_error), 16'(m_pe));
`endif
   endtask

   task automatic reset_model();
      q.delete();
      m_ov = 1'b0;
      m_fe = 1'b0;
      m_pe = 1'b0;
   endtask

   // p10 is the bit period in tenths of a clock; bit edges land on rounded-down multiples
   task automatic send_frame(input logic [8:0] d, input int p10, input bit stop_v, input bit bad_par, input int gap);
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(d[i]);
      if (PAR_EN) bits.push_back((^d[DB-1:0]) ^ bad_par);
      bits.push_back(stop_v);
      foreach (bits[i]) begin
         serial_in = bits[i];
         repeat (((i + 1) * p10) / 10 - (i * p10) / 10) @(negedge tb_clk);
      end
      serial_in = 1'b1;
      repeat (gap) @(negedge tb_clk);
      m_fe = !stop_v;
      m_pe = bad_par & PAR_EN;
      if (stop_v && !m_pe) begin
         if (q.size() < DEPTH) q.push_back(d[DB-1:0]);
         else m_ov = 1'b1;
      end
   endtask

   task automatic pop_word();
      data_read = 1'b1;
      @(negedge tb_clk);
      data_read = 1'b0;
      @(negedge tb_clk);
      if (q.size() != 0) void'(q.pop_front());
      m_ov = 1'b0;
   endtask

   initial begin
      reset_model();
      #2 n_rst = 1'b0;
      repeat (3) @(negedge tb_clk);
      check_all("reset");
      n_rst = 1'b1;
      repeat (4) @(negedge tb_clk);
      send_frame(9'h0D5, 100, 1'b1, 1'b0, 6);
      check_all("d5");
      pop_word();
      check_all("d5_read");
      send_frame(9'h0D5, 96, 1'b1, 1'b0, 6);
      send_frame(9'h0D5, 104, 1'b1, 1'b0, 6);
      check_all("drift");
      pop_word();
      check_all("drift_read1");
      pop_word();
      check_all("drift_read2");
      for (int v = 1; v <= 5; v++) send_frame(9'(v), 100, 1'b1, 1'b0, 5);
      check_all("overrun");
      for (int k = 0; k < DEPTH; k++) begin
         pop_word();
         check_all("overrun_drain");
      end
      pop_word();
      check_all("empty_read");
      send_frame(9'h0D5, 100, 1'b0, 1'b0, 6);
      check_all("framing_bad");
      send_frame(9'h06A, 100, 1'b1, 1'b0, 6);
      check_all("framing_clear");
      pop_word();
      serial_in = 1'b0;
      repeat (5) @(negedge tb_clk);
      serial_in = 1'b1;
      repeat (30) @(negedge tb_clk);
      check_all("glitch");
`ifdef RCV_PARITY_EN
      send_frame(9'h035, 100, 1'b1, 1'b1, 6);
      check_all("parity_bad");
      send_frame(9'h035, 100, 1'b1, 1'b0, 6);
      check_all("parity_good");
      pop_word();
`endif
      send_frame(9'h03C, 100, 1'b1, 1'b0, 0);
      send_frame(9'h0A5, 100, 1'b1, 1'b0, 6);
      check_all("back2back");
      pop_word();
      check_all("back2back_read");
      pop_word();
      for (int k = 0; k < 12; k++) begin
         send_frame(9'($urandom), int'($urandom_range(96, 104)), $urandom_range(0, 4) != 0, 1'b0,
                    int'($urandom_range(4, 12)));
         check_all("random");
         if ($urandom_range(0, 1) == 1) begin
            pop_word();
            check_all("random_read");
         end
      end
      repeat (DEPTH) pop_word();
      check_all("random_drain");
      serial_in = 1'b0;
      repeat (40) @(negedge tb_clk);
      n_rst = 1'b0;
      #1;
      reset_model();
      check_all("reset_mid");
      serial_in = 1'b1;
      repeat (3) @(negedge tb_clk);
      n_rst = 1'b1;
      repeat (5) @(negedge tb_clk);
      check_all("after_reset");
      send_frame(9'h081, 100, 1'b1, 1'b0, 6);
      check_all("after_reset_frame");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
